// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
// Optional feature: KEYPAD_ASCII_EN selects ASCII key codes on out.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 4;

    typedef struct packed {
        logic       hit;
        logic [1:0] row;
        logic [1:0] col;
    } scan_res_t;

    localparam int RES_W = $bits(scan_res_t);

    // Entry index is {row, col}; row 0 is "123A", column 0 is leftmost.
    localparam logic [15:0][6:0] KEY_ASCII = {
        7'h44, 7'h23, 7'h30, 7'h2A,
        7'h43, 7'h39, 7'h38, 7'h37,
        7'h42, 7'h36, 7'h35, 7'h34,
        7'h41, 7'h33, 7'h32, 7'h31
    };

    function automatic logic [6:0] key_ascii(
        input logic [1:0] row,
        input logic [1:0] col
    );
        return KEY_ASCII[{row, col}];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Accepts a scan result once DEBOUNCE consecutive scans agree.
// Release (no key) is debounced exactly like a press.
module keypad_debounce #(
    parameter int DEBOUNCE = 2,
    parameter int W        = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    input  logic [W-1:0] i_result,
    output logic [W-1:0] o_result
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE);

    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_prev;
    logic [W-1:0]  r_result;
    logic [CW-1:0] w_cnt_nxt;

    always_comb begin
        w_cnt_nxt = CW'(1);
        if (i_result == r_prev) begin
            if (r_cnt == CNT_MAX)
                w_cnt_nxt = CNT_MAX;
            else
                w_cnt_nxt = r_cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_prev   <= '0;
            r_result <= '0;
        end else if (i_valid) begin
            r_prev <= i_result;
            r_cnt  <= w_cnt_nxt;
            if (w_cnt_nxt == CNT_MAX)
                r_result <= i_result;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/keypad_peripheral.sv
// 4x4 matrix keypad scanner with per-scan priority resolve and debounce.
// Define KEYPAD_ASCII_EN for ASCII key codes instead of raw row/col.
module keypad_peripheral
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV = 1,
    parameter int DEBOUNCE = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_ROWS-1:0] rows,
    output logic [NUM_COLS-1:0] cols,
    output logic [7:0]          out
);

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

    logic [DW-1:0]       r_div;
    logic [1:0]          r_col;
    logic [NUM_COLS-1:0] r_cols;
    logic                w_slot_last;

    logic [NUM_ROWS-1:0] r_rows_s1;
    logic [NUM_ROWS-1:0] r_rows_s2;
    logic [1:0]          r_col_d1;
    logic [1:0]          r_col_d2;
    logic                r_tag_d1;
    logic                r_tag_d2;

    scan_res_t           r_best;
    scan_res_t           w_cand;
    scan_res_t           w_base;
    scan_res_t           w_merge;
    logic                w_scan_end;

    logic [RES_W-1:0]    w_acc_bits;
    scan_res_t           w_acc;
    logic [7:0]          w_code;
    logic [7:0]          r_out;

    assign w_slot_last = (r_div == DIV_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div  <= '0;
            r_col  <= '0;
            r_cols <= 4'b0001;
        end else if (w_slot_last) begin
            r_div  <= '0;
            r_col  <= r_col + 2'd1;
            r_cols <= {r_cols[NUM_COLS-2:0], r_cols[NUM_COLS-1]};
        end else begin
            r_div <= r_div + DW'(1);
        end
    end

    // Column index and slot-end tag travel with the row synchronizer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rows_s1 <= '0;
            r_rows_s2 <= '0;
            r_col_d1  <= '0;
            r_col_d2  <= '0;
            r_tag_d1  <= 1'b0;
            r_tag_d2  <= 1'b0;
        end else begin
            r_rows_s1 <= rows;
            r_rows_s2 <= r_rows_s1;
            r_col_d1  <= r_col;
            r_col_d2  <= r_col_d1;
            r_tag_d1  <= w_slot_last;
            r_tag_d2  <= r_tag_d1;
        end
    end

    always_comb begin
        w_cand = '0;
        for (int r = NUM_ROWS - 1; r >= 0; r--) begin
            if (r_rows_s2[r]) begin
                w_cand.hit = 1'b1;
                w_cand.row = 2'(r);
                w_cand.col = r_col_d2;
            end
        end
    end

    // Columns arrive in ascending order, so a strict row compare keeps
    // the lower column on a tie.
    always_comb begin
        w_base  = (r_col_d2 == 2'd0) ? '0 : r_best;
        w_merge = w_base;
        if (w_cand.hit && (!w_base.hit || (w_cand.row < w_base.row)))
            w_merge = w_cand;
    end

    assign w_scan_end = r_tag_d2 && (r_col_d2 == 2'(NUM_COLS - 1));

    always_ff @(posedge clk) begin
        if (rst)
            r_best <= '0;
        else if (r_tag_d2)
            r_best <= w_merge;
    end

    keypad_debounce #(
        .DEBOUNCE (DEBOUNCE),
        .W        (RES_W)
    ) u_debounce (
        .clk      (clk),
        .rst      (rst),
        .i_valid  (w_scan_end),
        .i_result (w_merge),
        .o_result (w_acc_bits)
    );

    assign w_acc = w_acc_bits;

    always_comb begin
        w_code = 8'h00;
        if (w_acc.hit) begin
`ifdef KEYPAD_ASCII_EN
            w_code = {1'b1, key_ascii(w_acc.row, w_acc.col)};
`else
            w_code = {1'b1, 3'b000, w_acc.row, w_acc.col};
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_out <= 8'h00;
        else
            r_out <= w_code;
    end

    assign cols = r_cols;
    assign out  = r_out;

endmodule

// File: tb/tb_keypad_peripheral.sv
// Scoreboard bench: key-matrix model drives rows, monitor checks out changes.
// Honors KEYPAD_ASCII_EN for the expected code format.
module tb_keypad_peripheral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] rows;
    logic [3:0] cols;
    logic [7:0] out;

    logic [15:0] keys = 16'h0000;
    logic [7:0]  exp_q[$];
    logic [7:0]  last_exp = 8'h00;
    logic [7:0]  seen_out = 8'h00;
    logic        mon_en = 1'b0;
    int          compared = 0;
    int          mismatched = 0;

    always #5 clk = ~clk;

    keypad_peripheral #(
        .SCAN_DIV (1),
        .DEBOUNCE (2)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .rows (rows),
        .cols (cols),
        .out  (out)
    );

    // Physical key matrix: row r reads high when a pressed key in the
    // driven column sits on that row. keys bit index is row*4+col.
    always_comb begin
        rows = 4'b0000;
        for (int r = 0; r < 4; r++)
            rows[r] = |(keys[r*4 +: 4] & cols);
    end

    function automatic logic [7:0] model(input logic [15:0] k);
        string      lay;
        byte        ch;
        logic [7:0] code;
        logic       found;
        lay   = "123A456B789C*0#D";
        code  = 8'h00;
        found = 1'b0;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!found && k[r*4+c]) begin
                    found = 1'b1;
                    ch    = lay[r*4+c];
`ifdef KEYPAD_ASCII_EN
                    code = {1'b1, ch[6:0]};
`else
                    code = {1'b1, 3'b000, 2'(r), 2'(c)};
`endif
                end
            end
        end
        return code;
    endfunction

    always @(negedge clk) begin
        if (mon_en && (out !== seen_out)) begin
            logic [7:0] e;
            seen_out = out;
            compared++;
            if (exp_q.size() == 0) begin
                mismatched++;
                $display("FAIL unexpected_change: out=%h, no change expected (hold %h)",
                         out, last_exp);
            end else begin
                e = exp_q.pop_front();
                if (out !== e) begin
                    mismatched++;
                    $display("FAIL out_change: out=%h required=%h", out, e);
                end
            end
        end
    end

    task automatic settle_check(input string tag, input logic [15:0] k);
        compared++;
        if (exp_q.size() != 0 || out !== last_exp) begin
            mismatched++;
            $display("FAIL %s: keys=%h out=%h required=%h pending=%0d",
                     tag, k, out, last_exp, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Hold a key set; the resulting code must be on out within 15 cycles.
    task automatic hold_keys(input logic [15:0] k);
        logic [7:0] e;
        e    = model(k);
        keys = k;
        if (e != last_exp) begin
            exp_q.push_back(e);
            last_exp = e;
        end
        repeat (15) @(negedge clk);
        settle_check("latency", k);
        repeat (6) @(negedge clk);
    endtask

    // Press a key set for exactly one scan length, then go back.
    task automatic bounce(input logic [15:0] k);
        logic [15:0] base;
        base = keys;
        keys = k;
        repeat (4) @(negedge clk);
        keys = base;
        repeat (20) @(negedge clk);
        settle_check("bounce", k);
    endtask

    initial begin
        logic [15:0] dir_keys[10];
        logic [15:0] m;
        dir_keys = '{16'h0000, 16'h000F, 16'h00F0, 16'h0F00, 16'hF000,
                     16'h0400, 16'h0000, 16'h0040, 16'h1000, 16'h0000};

        repeat (3) @(negedge clk);
        compared++;
        if (cols !== 4'b0001) begin
            mismatched++;
            $display("FAIL reset_cols: cols=%b required=0001", cols);
        end
        compared++;
        if (out !== 8'h00) begin
            mismatched++;
            $display("FAIL reset_out: out=%h required=00", out);
        end

        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            logic [3:0] ec;
            ec = 4'b0001 << (i % 4);
            compared++;
            if (cols !== ec) begin
                mismatched++;
                $display("FAIL col_rotate[%0d]: cols=%b required=%b", i, cols, ec);
            end
            @(negedge clk);
        end

        seen_out = out;
        mon_en   = 1'b1;

        for (int i = 0; i < 10; i++) begin
            hold_keys(dir_keys[i]);
            if (i == 6)
                bounce(16'h000F);
        end

        for (int i = 0; i < 30; i++) begin
            m = 16'($urandom & $urandom & $urandom);
            if ($urandom_range(0, 4) == 0)
                m = 16'h0000;
            if ($urandom_range(0, 3) == 0)
                bounce(m);
            else
                hold_keys(m);
        end

        hold_keys(16'h0000);
        repeat (30) @(negedge clk);
        settle_check("idle_final", 16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
